fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register; drives instOut into the decoder's instIn.

---
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_stage.sv | 126 ++++++++++++
 tb/tb_fetch_stage.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory request/response bundle for the fetch stage
`timescale 1ns/1ps

interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with 1-entry stall buffer and IF/ID register
`timescale 1ns/1ps

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master imem,
    input  logic          stall,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic [31:0]   instOut,
    output logic [31:0]   pcOut,
    output logic          instValid
);

    // S_FULL doubles as the buffer-occupied flag; S_DRAIN waits out a stale response.
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_FULL, S_DRAIN} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] buf_data;
    logic [31:0] load_data;
    logic        load_id;
    logic        buf_we;

    assign imem.imem_req  = (state == S_FETCH) && !redirect_valid;
    assign imem.imem_addr = pc & 32'hFFFF_FFFC;

    // Next state, next PC and IF/ID load decision; redirect overrides everything.
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        load_id   = 1'b0;
        load_data = buf_data;
        buf_we    = 1'b0;

        case (state)
            S_FETCH: begin
                if (imem.imem_req && imem.imem_gnt) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    if (!stall) begin
                        load_id   = 1'b1;
                        load_data = imem.imem_rdata;
                        pc_n      = pc + 32'd4;
                        state_n   = S_FETCH;
                    end else begin
                        buf_we  = 1'b1;
                        state_n = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (!stall) begin
                    load_id   = 1'b1;
                    load_data = buf_data;
                    pc_n      = pc + 32'd4;
                    state_n   = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (imem.imem_rvalid) begin
                    state_n = S_FETCH;
                end
            end
            default: state_n = S_FETCH;
        endcase

        if (redirect_valid) begin
            pc_n    = redirect_pc & 32'hFFFF_FFFC;
            load_id = 1'b0;
            buf_we  = 1'b0;
            // A request still in flight must be drained before the next one issues.
            if ((state == S_WAIT || state == S_DRAIN) && !imem.imem_rvalid) begin
                state_n = S_DRAIN;
            end else begin
                state_n = S_FETCH;
            end
        end
    end

    // FSM state, PC and stall buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            buf_data <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            if (redirect_valid) begin
                buf_data <= '0;
            end else if (buf_we) begin
                buf_data <= imem.imem_rdata;
            end
        end
    end

    // IF/ID pipeline register: flush on redirect, hold on stall, otherwise load or bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instOut   <= NOP_INST;
            pcOut     <= '0;
            instValid <= 1'b0;
        end else if (redirect_valid) begin
            instOut   <= NOP_INST;
            instValid <= 1'b0;
        end else if (!stall) begin
            if (load_id) begin
                instOut   <= load_data;
                pcOut     <= pc;
                instValid <= 1'b1;
            end else begin
                instOut   <= NOP_INST;
                instValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized bench for fetch_stage against a sequential-stream model
`timescale 1ns/1ps

module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instOut;
    logic [31:0] pcOut;
    logic        instValid;

    fetch_stage_if imem ();

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (imem),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instOut        (instOut),
        .pcOut          (pcOut),
        .instValid      (instValid)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
    endfunction

    // Model: program order stream, ID slot content, one-deep holding slot, memory side.
    logic [31:0] exp_pc;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        buffered;
    logic        outstanding;
    logic        stale;
    logic [31:0] resp_addr;
    int          cnt;
    int          gnt_hold;
    int          quiet;
    int          delivered = 0;

    logic        stall_d, redir_d, rvalid_d, req_d, gnt_d;
    logic [31:0] target_d, addr_d;

    task automatic do_reset();
        rst               = 1'b1;
        stall             = 1'b0;
        redirect_valid    = 1'b0;
        redirect_pc       = '0;
        imem.imem_gnt     = 1'b0;
        imem.imem_rvalid  = 1'b0;
        imem.imem_rdata   = '0;
        @(negedge clk);
        @(negedge clk);
        rst         = 1'b0;
        exp_pc      = 32'h0;
        id_valid    = 1'b0;
        id_inst     = NOP;
        id_pc       = 32'h0;
        buffered    = 1'b0;
        outstanding = 1'b0;
        stale       = 1'b0;
        resp_addr   = '0;
        cnt         = 0;
        gnt_hold    = 0;
        check("rst_valid", {31'b0, instValid}, 32'd0);
        check("rst_inst", instOut, NOP);
        check("rst_pc", pcOut, 32'h0);
    endtask

    task automatic drive_and_check_req();
        if (quiet > 0) begin
            quiet--;
            stall          = 1'b0;
            redirect_valid = 1'b0;
            redirect_pc    = '0;
            imem.imem_gnt  = 1'b1;
        end else begin
            stall          = ($urandom_range(0, 9) < 3);
            redirect_valid = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 32'h0000_0102;
                1:       redirect_pc = 32'hFFFF_FFF8;
                2:       redirect_pc = 32'hFFFF_FFFC;
                default: redirect_pc = $urandom;
            endcase
            if (gnt_hold > 0) begin
                imem.imem_gnt = 1'b0;
                gnt_hold--;
            end else begin
                imem.imem_gnt = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 29) == 0) gnt_hold = 5;
            end
        end
        imem.imem_rvalid = outstanding && (cnt == 0);
        imem.imem_rdata  = imem.imem_rvalid ? mem_word(resp_addr) : $urandom;
        #1;
        check("req", {31'b0, imem.imem_req}, {31'b0, (!outstanding && !buffered && !redirect_valid)});
        if (imem.imem_req) check("addr", imem.imem_addr, exp_pc);
        stall_d  = stall;
        redir_d  = redirect_valid;
        target_d = redirect_pc;
        rvalid_d = imem.imem_rvalid;
        req_d    = imem.imem_req;
        gnt_d    = imem.imem_gnt;
        addr_d   = imem.imem_addr;
    endtask

    task automatic step_and_compare();
        logic live;
        live = rvalid_d && !stale && !redir_d;
        if (redir_d) begin
            id_valid = 1'b0;
            id_inst  = NOP;
            buffered = 1'b0;
            exp_pc   = target_d & 32'hFFFF_FFFC;
            if (outstanding) stale = 1'b1;
        end else if (!stall_d) begin
            if (buffered || live) begin
                id_valid = 1'b1;
                id_pc    = exp_pc;
                id_inst  = mem_word(exp_pc);
                exp_pc   = exp_pc + 32'd4;
                buffered = 1'b0;
                delivered++;
            end else begin
                id_valid = 1'b0;
                id_inst  = NOP;
            end
        end else if (live) begin
            buffered = 1'b1;
        end
        if (rvalid_d) outstanding = 1'b0;
        else if (outstanding) cnt--;
        if (req_d && gnt_d) begin
            outstanding = 1'b1;
            stale       = 1'b0;
            resp_addr   = addr_d;
            cnt         = (quiet > 0) ? 0 : $urandom_range(0, 2);
        end
        check("valid", {31'b0, instValid}, {31'b0, id_valid});
        check("inst", instOut, id_inst);
        if (id_valid) check("pc", pcOut, id_pc);
    endtask

    initial begin
        do_reset();
        quiet = 4;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc == 2000) do_reset();
            drive_and_check_req();
            @(negedge clk);
            step_and_compare();
            if (cyc == 1) begin
                check("t1_inst", instOut, 32'h0050_0093);
                check("t1_pc", pcOut, 32'h0);
                check("t1_valid", {31'b0, instValid}, 32'd1);
            end
        end
        check("progress", {31'b0, (delivered > 300)}, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
